// File: rtl/two2one_if.sv
// two2one_if -- symbol handshake and serial line bundle for the two2one
// dibit-to-serial transmitter.
//   in_data     2  symbol from producer, in_data[1] goes on the line first
//   in_valid    1  producer has a symbol on in_data
//   in_ready    1  transmitter accepts in_data on the next rising edge
//   output_data 1  registered serial line, idles at 0
//   busy        1  frame in preamble, payload or guard gap
//   frame_done  1  one-cycle pulse on the first guard-gap cycle
// master: the symbol producer. slave: the transmitter.
interface two2one_if;
    logic [1:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       output_data;
    logic       busy;
    logic       frame_done;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  output_data,
        input  busy,
        input  frame_done
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output output_data,
        output busy,
        output frame_done
    );
endinterface

// File: rtl/two2one.sv
// two2one -- dibit-to-serial framing transmitter.
// Collects SYMBOLS dibits over a valid/ready handshake, then drives the frame
// onto a 1-bit line: "11" preamble, payload MSB first, GAP_LEN zero bits.
// Ports:
//   clk    rising-edge system clock
//   reset  asynchronous active-high reset, returns to LOAD and drops the frame
//   bus    two2one_if.slave: in_data/in_valid in; in_ready, output_data,
//          busy, frame_done out (all registered)
module two2one #(
    parameter int SYMBOLS = 8,
    parameter int GAP_LEN = 2
) (
    input  logic       clk,
    input  logic       reset,
    two2one_if.slave   bus
);
    localparam int FW = 2 * SYMBOLS;
    localparam int SW = $clog2(SYMBOLS + 1);
    localparam int BW = $clog2(FW);
    localparam int GW = $clog2(GAP_LEN + 1);

    localparam logic [SW-1:0] SYM_LAST  = SW'(SYMBOLS - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(FW - 1);
    localparam logic [GW-1:0] GAP_FIRST = GW'(1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_LEN - 1);

    typedef enum logic [1:0] {
        LOAD,
        PRE,
        DATA,
        GAP
    } state_t;

    state_t          state;
    logic [FW-1:0]   frame;
    logic [SW-1:0]   sym_cnt;
    logic [BW-1:0]   bit_cnt;
    logic [GW-1:0]   gap_cnt;
    logic            pre_flag;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= LOAD;
            frame           <= '0;
            sym_cnt         <= '0;
            bit_cnt         <= '0;
            gap_cnt         <= '0;
            pre_flag        <= 1'b0;
            bus.output_data <= 1'b0;
            bus.in_ready    <= 1'b1;
            bus.busy        <= 1'b0;
            bus.frame_done  <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (bus.in_valid && bus.in_ready) begin
                        frame   <= {frame[FW-3:0], bus.in_data};
                        sym_cnt <= sym_cnt + SW'(1);
                        // The accepting edge already drives the first preamble bit.
                        if (sym_cnt == SYM_LAST) begin
                            state           <= PRE;
                            bus.in_ready    <= 1'b0;
                            bus.busy        <= 1'b1;
                            bus.output_data <= 1'b1;
                        end
                    end
                end

                PRE: begin
                    if (!pre_flag) begin
                        pre_flag <= 1'b1;
                    end else begin
                        bus.output_data <= frame[FW-1];
                        frame           <= {frame[FW-2:0], 1'b0};
                        bit_cnt         <= '0;
                        state           <= DATA;
                    end
                end

                DATA: begin
                    // bit_cnt counts payload bits already on the line beyond the first.
                    if (bit_cnt == BIT_LAST) begin
                        bus.output_data <= 1'b0;
                        bus.frame_done  <= 1'b1;
                        gap_cnt         <= GAP_FIRST;
                        state           <= GAP;
                    end else begin
                        bus.output_data <= frame[FW-1];
                        frame           <= {frame[FW-2:0], 1'b0};
                        bit_cnt         <= bit_cnt + BW'(1);
                    end
                end

                GAP: begin
                    bus.frame_done <= 1'b0;
                    // The returning LOAD cycle is the last zero of the gap.
                    if (gap_cnt == GAP_LAST) begin
                        state        <= LOAD;
                        bus.in_ready <= 1'b1;
                        bus.busy     <= 1'b0;
                        sym_cnt      <= '0;
                        bit_cnt      <= '0;
                        gap_cnt      <= '0;
                        pre_flag     <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end

                default: state <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_two2one.sv
module tb_two2one;
    logic clk;
    logic reset;

    two2one_if bus1 ();
    two2one_if bus2 ();

    two2one #(.SYMBOLS(8), .GAP_LEN(2)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
    two2one #(.SYMBOLS(8), .GAP_LEN(4)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int sel   = 0;   // 0: dut1 (gap 2), 1: dut2 (gap 4)

    // Reference model: symbols collected into a frame, then a queue of line bits.
    bit         m_rdy = 1'b1;
    bit         m_took;
    bit         e_out, e_done;
    int         m_pos;
    logic [1:0] m_syms[$];
    bit         m_line[$];
    logic [1:0] m_acc[$];
    logic [1:0] stim[$];

    // Loopback receiver: sync on two ones from idle, capture 16 bits as 8 dibits.
    bit         rx_prev;
    bit         rx_cap;
    int         rx_cnt;
    logic [15:0] rx_word;
    logic [1:0] rx_q[$];

    bit         h_out[$];
    bit         h_rdy[$];

    typedef struct {
        logic       v;
        logic [1:0] d;
        logic       e_out;
        logic       e_rdy;
        logic       e_busy;
        logic       e_done;
    } vec_t;
    vec_t tbl[27];

    task automatic cmp1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmpn(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic a_out();  return (sel != 0) ? bus2.output_data : bus1.output_data; endfunction
    function automatic logic a_rdy();  return (sel != 0) ? bus2.in_ready    : bus1.in_ready;    endfunction
    function automatic logic a_busy(); return (sel != 0) ? bus2.busy        : bus1.busy;        endfunction
    function automatic logic a_done(); return (sel != 0) ? bus2.frame_done  : bus1.frame_done;  endfunction

    task automatic rx_feed(input bit b);
        if (!rx_cap) begin
            if (rx_prev && b) begin
                rx_cap  = 1'b1;
                rx_cnt  = 0;
                rx_prev = 1'b0;
            end else begin
                rx_prev = b;
            end
        end else begin
            rx_word = {rx_word[14:0], b};
            rx_cnt++;
            if (rx_cnt == 16) begin
                for (int i = 7; i >= 0; i--) rx_q.push_back(rx_word[2*i +: 2]);
                rx_cap  = 1'b0;
                rx_prev = 1'b0;
            end
        end
    endtask

    task automatic model_reset();
        m_rdy = 1'b1;
        m_pos = 0;
        m_syms.delete();
        m_line.delete();
        m_acc.delete();
        rx_prev = 1'b0;
        rx_cap  = 1'b0;
        rx_cnt  = 0;
        rx_word = '0;
        rx_q.delete();
        h_out.delete();
        h_rdy.delete();
    endtask

    task automatic model_edge(input logic v, input logic [1:0] d);
        int gap;
        gap    = (sel != 0) ? 4 : 2;
        m_took = 1'b0;
        e_out  = 1'b0;
        e_done = 1'b0;
        if (m_rdy && v) begin
            m_took = 1'b1;
            m_acc.push_back(d);
            m_syms.push_back(d);
            if (m_syms.size() == 8) begin
                m_line.delete();
                m_line.push_back(1'b1);
                m_line.push_back(1'b1);
                foreach (m_syms[i]) begin
                    m_line.push_back(m_syms[i][1]);
                    m_line.push_back(m_syms[i][0]);
                end
                for (int g = 0; g < gap; g++) m_line.push_back(1'b0);
                m_syms.delete();
                m_rdy = 1'b0;
                m_pos = 0;
            end
        end
        if (m_line.size() != 0) begin
            e_out  = m_line.pop_front();
            e_done = (m_pos == 18);
            m_pos++;
            if (m_line.size() == 0) m_rdy = 1'b1;
        end
    endtask

    task automatic step(input logic v, input logic [1:0] d);
        if (sel == 0) begin
            bus1.in_valid = v;  bus1.in_data = d;  bus2.in_valid = 1'b0;
        end else begin
            bus2.in_valid = v;  bus2.in_data = d;  bus1.in_valid = 1'b0;
        end
        @(posedge clk);
        model_edge(v, d);
        #1;
        h_out.push_back(a_out());
        h_rdy.push_back(a_rdy());
        rx_feed(a_out());
    endtask

    task automatic check_model();
        cmp1("line", a_out(), e_out);
        cmp1("in_ready", a_rdy(), m_rdy);
        cmp1("busy", a_busy(), !m_rdy);
        cmp1("frame_done", a_done(), e_done);
    endtask

    task automatic check_idle(input string name);
        cmp1({name, "_line"}, a_out(), 1'b0);
        cmp1({name, "_in_ready"}, a_rdy(), 1'b1);
        cmp1({name, "_busy"}, a_busy(), 1'b0);
        cmp1({name, "_frame_done"}, a_done(), 1'b0);
    endtask

    task automatic do_reset();
        bus1.in_valid = 1'b0;
        bus2.in_valid = 1'b0;
        reset = 1'b1;
        #1;
        check_idle("reset");
        @(posedge clk);
        #1;
        check_idle("reset_hold");
        reset = 1'b0;
        model_reset();
    endtask

    // mode 0: continuous valid, 1: valid 1,0,0 pattern, 2: random valid.
    // While the model says busy, valid follows the mode with garbage data.
    task automatic run(input int mode);
        int         idx, cyc, max_cyc;
        logic       v;
        logic [1:0] d;
        idx = 0;
        cyc = 0;
        max_cyc = stim.size() * 8 + 100;
        while ((idx < stim.size() || !m_rdy) && cyc < max_cyc) begin
            d = 2'($urandom);
            if (m_rdy && idx < stim.size()) d = stim[idx];
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 3 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            step(v, d);
            check_model();
            if (m_took) idx++;
            cyc++;
        end
        n_vec++;
        if (cyc >= max_cyc) begin
            n_bad++;
            $display("FAIL run_bound: got %0d cycles expected fewer than %0d", cyc, max_cyc);
        end
        stim.delete();
    endtask

    task automatic rx_check(input string name);
        int n;
        cmpn({name, "_rx_count"}, rx_q.size(), m_acc.size());
        n = (rx_q.size() < m_acc.size()) ? rx_q.size() : m_acc.size();
        for (int i = 0; i < n; i++) cmpn({name, "_rx_dibit"}, int'(rx_q[i]), int'(m_acc[i]));
        rx_q.delete();
        m_acc.delete();
    endtask

    task automatic add_word(input logic [15:0] w);
        for (int i = 7; i >= 0; i--) stim.push_back(w[2*i +: 2]);
    endtask

    initial begin
        logic [1:0]  basic[8];
        logic [19:0] line_exp;
        int          k, zeros;

        reset = 1'b1;
        bus1.in_valid = 1'b0; bus1.in_data = '0;
        bus2.in_valid = 1'b0; bus2.in_data = '0;

        basic = '{2'b11, 2'b00, 2'b10, 2'b01, 2'b11, 2'b01, 2'b00, 2'b10};
        line_exp = {2'b11, 16'hC9D2, 2'b00};
        for (int j = 0; j < 27; j++) begin
            tbl[j].v = (j < 8);
            tbl[j].d = (j < 8) ? basic[j] : 2'b00;
            if (j < 7) begin
                tbl[j].e_out = 1'b0; tbl[j].e_rdy = 1'b1; tbl[j].e_busy = 1'b0; tbl[j].e_done = 1'b0;
            end else begin
                tbl[j].e_out  = line_exp[19 - (j - 7)];
                tbl[j].e_rdy  = (j - 7 == 19);
                tbl[j].e_busy = (j - 7 != 19);
                tbl[j].e_done = (j - 7 == 18);
            end
        end

        #12;
        sel = 0;
        do_reset();

        // Basic frame from the table.
        for (int j = 0; j < 27; j++) begin
            step(tbl[j].v, tbl[j].d);
            cmp1("tbl_line", a_out(), tbl[j].e_out);
            cmp1("tbl_in_ready", a_rdy(), tbl[j].e_rdy);
            cmp1("tbl_busy", a_busy(), tbl[j].e_busy);
            cmp1("tbl_frame_done", a_done(), tbl[j].e_done);
        end
        rx_check("basic");

        // Loopback with backpressure: valid stays high, data changes while busy.
        add_word(16'h0000);
        add_word(16'hFFFF);
        add_word(16'hA5C3);
        run(0);
        rx_check("loopback");

        // Input stalls during load.
        for (int i = 0; i < 8; i++) stim.push_back(2'($urandom));
        run(1);
        rx_check("stall");

        // Random frames with random valid.
        for (int i = 0; i < 40; i++) stim.push_back(2'($urandom));
        run(2);
        rx_check("random");

        // Reset in the middle of the payload.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 2'($urandom));
            check_model();
        end
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 2'b00);
            check_model();
        end
        #2;
        reset = 1'b1;
        #1;
        check_idle("reset_mid");
        @(posedge clk);
        #1;
        check_idle("reset_mid_hold");
        reset = 1'b0;
        model_reset();
        add_word(16'h3C5A);
        run(0);
        rx_check("after_reset");

        // Gap of four on the second instance, two back-to-back frames.
        sel = 1;
        do_reset();
        add_word(16'h96E1);
        add_word(16'hFFFF);
        run(0);
        rx_check("gap4");
        k = -1;
        for (int i = 0; i < h_rdy.size(); i++) begin
            if (k < 0 && h_rdy[i] == 1'b0) k = i;
        end
        cmpn("gap4_accept_edge", k, 7);
        if (k >= 0 && h_out.size() > k + 30) begin
            zeros = 0;
            for (int i = k + 18; i <= k + 21; i++) if (h_out[i] == 1'b0) zeros++;
            cmpn("gap4_zeros", zeros, 4);
            cmp1("gap4_rdy_low", h_rdy[k + 20], 1'b0);
            cmp1("gap4_rdy_rise", h_rdy[k + 21], 1'b1);
            cmp1("gap4_pre_before", h_out[k + 28], 1'b0);
            cmp1("gap4_pre_start", h_out[k + 29], 1'b1);
        end else begin
            n_vec++;
            n_bad++;
            $display("FAIL gap4_history: got %0d samples expected more than %0d", h_out.size(), k + 30);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
